pipelined_ripple_adder: RTL
===========================

# pipelined_ripple_adder

Parametrised, pipelined carry-chain adder/subtractor that generalises the team's 4-bit combinational ripple adder to arbitrary width. The carry ripples through `SEG`-bit segments, with one register stage per segment, so throughput is one operation per clock at any width. It sits between operand producers and result consumers on valid/ready streams, and supports add and subtract per transaction with carry/borrow and signed-overflow outputs.

## Interface
- `WIDTH`, 16: operand/result width in bits; must be a multiple of `SEG`.
- `SEG`, 4: bits resolved per pipeline stage. `STAGES = WIDTH/SEG` (derived, not overridable).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: operand transaction present.
- `in_ready` output 1: block accepts a transaction this cycle.
- `in_a` input WIDTH: operand A, unsigned or two's complement.
- `in_b` input WIDTH: operand B.
- `in_cin` input 1: carry-in for add; borrow-in for subtract.
- `in_sub` input 1: 0 = add, 1 = subtract.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts the result.
- `out_sum` output WIDTH: result.
- `out_cout` output 1: carry-out for add; NOT borrow for subtract.
- `out_ovf` output 1: signed overflow.

## Operation
- Add: `{out_cout,out_sum} = in_a + in_b + in_cin`.
- Subtract: `in_a + ~in_b + ~in_cin`, which gives `in_a - in_b - in_cin`. `out_cout = 1` means no borrow.
- `out_ovf` = carry into MSB XOR carry out of MSB. It is computed in the last stage.
- Stage k (0..STAGES-1) adds segment k of A and B' using the carry registered by stage k-1. Stage 0 uses the effective carry-in.
- Segments above k are carried forward unprocessed (input skew). Resolved lower segments are carried forward to the output (output deskew).
- Each stage holds a valid bit. Pipeline advance: `adv = !out_valid || out_ready`. All stages shift together when `adv` is high and hold otherwise.
- `in_ready = adv`. A transfer occurs when `in_valid && in_ready`. When `adv` is high and `in_valid` is low, a bubble (valid = 0) enters stage 0.
- Bubbles are not collapsed. Order is strictly preserved and no transaction is dropped or duplicated.
- `in_sub` and the carry-in are captured at transfer. Changing them later has no effect on in-flight operations.

## Timing
- Latency: a transfer at edge N produces `out_valid = 1` with its result after edge N+STAGES, assuming no stall. Default latency is 4 cycles.
- Throughput: 1 result per cycle while `out_ready` is held high.
- Output stall: `out_valid && !out_ready` holds `out_sum`, `out_cout` and `out_ovf` stable, drops `in_ready` combinationally in the same cycle, and freezes all stages.
- Simultaneous output pop and input push in one cycle is legal and is required at full rate.
- Reset values: `out_valid=0`, `out_sum=0`, `out_cout=0`, `out_ovf=0`, all stage valids 0. `in_ready` reads 1 once reset deasserts.
- Reset mid-flight discards all in-flight transactions immediately. No result from before reset ever appears.
- Data registers need no reset except the output registers. Valid bits must be reset.
- Combinational path per stage is one `SEG`-bit ripple plus a mux. `SEG` sets the timing/latency trade-off.

## Structure
- Shared package `adder_pkg`: `ADD`/`SUB` mode constants and a function that computes `STAGES` from `WIDTH`/`SEG`, with an elaboration check that `WIDTH % SEG == 0`.
- Sub-module `ripple_segment`: combinational `SEG`-bit ripple of full adders. It takes `a`, `b`, `cin` and returns `sum`, `cout`, and the carry into its MSB (used for `out_ovf` in the top segment).
- Top level: generate loop of `STAGES` instances plus the stage registers, skew/deskew registers and handshake logic.
- Expected size: 150–300 lines.

## Test plan
- Reset: assert `rst` mid-stream → all outputs 0 and `out_valid` 0 within the same cycle. After release, `in_ready=1` and no stale results appear.
- Full carry chain: A=0xFFFF, B=0x0001, cin=0, add → sum=0x0000, cout=1, ovf=0, with `out_valid` exactly 4 cycles after transfer.
- Subtract with borrow: A=0x0005, B=0x0007, cin=0, sub → sum=0xFFFE, cout=0, ovf=0. Then A=0x8000, B=0x0001, sub → sum=0x7FFF, cout=1, ovf=1.
- Signed add overflow: A=0x7FFF, B=0x0001, cin=1 → sum=0x8001, cout=0, ovf=1.
- Backpressure: 6 back-to-back ops (A=i, B=0x1000*i) with `out_ready` low for 3 cycles mid-stream → `in_ready` follows `adv`, outputs stay stable while stalled, all 6 results arrive in order, none lost.
- Parameter sweep: WIDTH=8/SEG=8 (latency 1) and WIDTH=32/SEG=4 (latency 8) with random operands, checked against a reference model of `a ± b ± c`, including the 0x…FF+1 wrap case.

Source files
------------

// File: rtl/pipelined_ripple_adder_pkg.sv
// adder_pkg: mode encodings and stage-count helper shared by the pipelined adder.
package adder_pkg;
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;
  function automatic int stages_f(input int width, input int seg);
    return width / seg;
  endfunction
endpackage

// File: rtl/pipelined_ripple_adder_if.sv
// pipelined_ripple_adder_if: operand and result valid/ready streams of the pipelined adder.
interface pipelined_ripple_adder_if #(
  parameter int WIDTH = 16
);
  logic in_valid, in_ready, in_cin, in_sub;
  logic out_valid, out_ready, out_cout, out_ovf;
  logic [WIDTH-1:0] in_a, in_b, out_sum;
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/pipelined_ripple_adder_ripple_segment.sv
// ripple_segment: combinational SEG-bit chain of full adders.
module ripple_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb
);
  logic [SEG:0] c;
  always_comb begin
    c[0] = cin;
    sum = '0;
    for (int i = 0; i < SEG; i++) begin
      sum[i] = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
  assign cout = c[SEG];
  assign c_msb = c[SEG-1];
endmodule

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: valid/ready add/subtract, one SEG-bit carry segment per pipeline stage.
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG = 4
) (
  input logic clk,
  input logic rst,
  pipelined_ripple_adder_if.slave bus
);
  localparam int STAGES = stages_f(WIDTH, SEG);
  if (WIDTH % SEG != 0) begin : g_chk
    $error("WIDTH must be a multiple of SEG");
  end
  logic adv;
  logic v_in_q, c_in_q;
  logic [WIDTH-1:0] a_in_q, b_in_q;
  logic v_w [STAGES];
  logic c_w [STAGES];
  logic [WIDTH-1:0] x_w [STAGES];
  logic [WIDTH-1:0] y_w [STAGES];
  logic valid_q, cout_q, ovf_q;
  logic [WIDTH-1:0] sum_q;
  assign adv = !valid_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = valid_q;
  assign bus.out_sum = sum_q;
  assign bus.out_cout = cout_q;
  assign bus.out_ovf = ovf_q;
  // B and the carry are conditioned for subtract once, at capture
  always_ff @(posedge clk or posedge rst)
    if (rst) v_in_q <= 1'b0;
    else if (adv) v_in_q <= bus.in_valid;
  always_ff @(posedge clk)
    if (adv) begin
      a_in_q <= bus.in_a;
      b_in_q <= bus.in_sub == ADD ? bus.in_b : ~bus.in_b;
      c_in_q <= bus.in_sub == ADD ? bus.in_cin : ~bus.in_cin;
    end
  assign v_w[0] = v_in_q;
  assign c_w[0] = c_in_q;
  assign x_w[0] = a_in_q;
  assign y_w[0] = b_in_q;
  // x shifts right each stage: pending A leaves at the bottom, resolved sum enters at the top
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0] s;
    logic co;
    logic [WIDTH-1:0] x_d;
    assign x_d = WIDTH'({s, x_w[k]} >> SEG);
    if (k == STAGES - 1) begin : g_last
      logic cm;
      ripple_segment #(.SEG(SEG)) u_seg (
        .a(x_w[k][SEG-1:0]), .b(y_w[k][SEG-1:0]), .cin(c_w[k]),
        .sum(s), .cout(co), .c_msb(cm)
      );
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          valid_q <= 1'b0;
          sum_q <= '0;
          cout_q <= 1'b0;
          ovf_q <= 1'b0;
        end else if (adv) begin
          valid_q <= v_w[k];
          sum_q <= x_d;
          cout_q <= co;
          ovf_q <= co ^ cm;
        end
    end else begin : g_mid
      logic v_q, c_q;
      logic [WIDTH-1:0] x_q, y_q, y_d;
      ripple_segment #(.SEG(SEG)) u_seg (
        .a(x_w[k][SEG-1:0]), .b(y_w[k][SEG-1:0]), .cin(c_w[k]),
        .sum(s), .cout(co), .c_msb()
      );
      assign y_d = y_w[k] >> SEG;
      always_ff @(posedge clk or posedge rst)
        if (rst) v_q <= 1'b0;
        else if (adv) v_q <= v_w[k];
      always_ff @(posedge clk)
        if (adv) begin
          x_q <= x_d;
          y_q <= y_d;
          c_q <= co;
        end
      assign v_w[k+1] = v_q;
      assign c_w[k+1] = c_q;
      assign x_w[k+1] = x_q;
      assign y_w[k+1] = y_q;
    end
  end
endmodule
